sdram_multiport_arbiter: RTL and testbench

N-port successor to the two-port CPU/video SDRAM arbiter. Sits between any number of bus masters (CPU memory controller, video scan-out, future blitter/audio DMA) and the single-request SDRAM controller. One transaction in flight at a time. Arbitration is fixed-priority for ports in a high-priority mask and round-robin for the rest. Burst reads and multi-beat data return are supported per port.

---
 rtl/sdram_arb_pkg.sv | 15 +
 rtl/rr_priority_picker.sv | 39 +++
 rtl/sdram_multiport_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_sdram_multiport_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_arb_pkg.sv
// Shared types for the multi-port SDRAM arbiter: FSM state encoding and the
// sizing helper for the read-beat counter.
package sdram_arb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StData
  } arb_state_e;

  function automatic int unsigned beat_cnt_w(int unsigned burst_len);
    return $clog2(burst_len + 1);
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational winner selection: lowest-index high-priority requester first,
// otherwise the first round-robin requester at or after the pointer.
module rr_priority_picker #(
  parameter int unsigned NumPorts = 4,
  parameter int unsigned PtrW     = 2
) (
  input  logic [NumPorts-1:0] req_i,
  input  logic [NumPorts-1:0] hipri_mask_i,
  input  logic [PtrW-1:0]     ptr_i,
  output logic [NumPorts-1:0] winner_o,
  output logic                valid_o
);

  logic [NumPorts-1:0]   hi_req;
  logic [NumPorts-1:0]   lo_req;
  logic [NumPorts-1:0]   hi_win;
  logic [NumPorts-1:0]   rot_req;
  logic [NumPorts-1:0]   rot_win;
  logic [NumPorts-1:0]   lo_win;
  logic [2*NumPorts-1:0] lo_dbl;
  logic [2*NumPorts-1:0] win_dbl;

  assign hi_req = req_i & hipri_mask_i;
  assign lo_req = req_i & ~hipri_mask_i;

  // Isolate lowest set bit.
  assign hi_win = hi_req & (~hi_req + 1'b1);

  // Rotate so the pointer lands on bit 0, pick lowest, rotate back.
  assign lo_dbl  = {lo_req, lo_req};
  assign rot_req = NumPorts'(lo_dbl >> ptr_i);
  assign rot_win = rot_req & (~rot_req + 1'b1);
  assign win_dbl = {rot_win, rot_win};
  assign lo_win  = NumPorts'((win_dbl << ptr_i) >> NumPorts);

  assign winner_o = (|hi_req) ? hi_win : lo_win;
  assign valid_o  = |req_i;

endmodule

// File: rtl/sdram_multiport_arbiter.sv
// N-port arbiter in front of a single-request SDRAM controller; one
// transaction in flight, fixed priority for HIPRI ports, round-robin otherwise.
module sdram_multiport_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int unsigned          NUM_PORTS  = 4,
  parameter int unsigned          ADDR_W     = 24,
  parameter int unsigned          DATA_W     = 16,
  parameter int unsigned          BURST_LEN  = 4,
  parameter logic [NUM_PORTS-1:0] BURST_MASK = NUM_PORTS'(4'b0010),
  parameter logic [NUM_PORTS-1:0] HIPRI_MASK = NUM_PORTS'(4'b0010)
) (
  input  logic                                clk_i,
  input  logic                                rst_n_i,
  input  logic [NUM_PORTS-1:0]                port_rd_i,
  input  logic [NUM_PORTS-1:0]                port_wr_i,
  input  logic [NUM_PORTS-1:0][ADDR_W-1:0]    port_addr_i,
  input  logic [NUM_PORTS-1:0][DATA_W-1:0]    port_wdata_i,
  input  logic [NUM_PORTS-1:0][1:0]           port_wmask_i,
  output logic [NUM_PORTS-1:0]                port_ack_o,
  output logic [NUM_PORTS-1:0]                port_rdy_o,
  output logic [DATA_W-1:0]                   port_rdata_o,
  output logic                                sdram_rd_o,
  output logic                                sdram_wr_o,
  output logic [ADDR_W-1:0]                   sdram_addr_o,
  output logic [DATA_W-1:0]                   sdram_wdata_o,
  output logic [1:0]                          sdram_wmask_o,
  output logic                                sdram_burst_o,
  input  logic                                sdram_ack_i,
  input  logic                                sdram_rdy_i,
  input  logic [DATA_W-1:0]                   sdram_rdata_i,
  output logic [NUM_PORTS-1:0]                grant_o
);

  localparam int unsigned PtrW = $clog2(NUM_PORTS);
  localparam int unsigned CntW = beat_cnt_w(BURST_LEN);

  arb_state_e             state_q, state_d;
  logic [NUM_PORTS-1:0]   grant_q, grant_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [DATA_W-1:0]      wdata_q, wdata_d;
  logic [1:0]             wmask_q, wmask_d;
  logic                   rd_q, rd_d;
  logic                   burst_q, burst_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [PtrW-1:0]        ptr_q, ptr_d;

  logic [NUM_PORTS-1:0]   winner;
  logic                   win_valid;
  logic [ADDR_W-1:0]      sel_addr;
  logic [DATA_W-1:0]      sel_wdata;
  logic [1:0]             sel_wmask;
  logic                   sel_rd;
  logic [PtrW-1:0]        sel_idx;
  logic [PtrW-1:0]        ptr_after;
  logic [CntW-1:0]        beats_left;

  rr_priority_picker #(
    .NumPorts (NUM_PORTS),
    .PtrW     (PtrW)
  ) u_picker (
    .req_i        (port_rd_i | port_wr_i),
    .hipri_mask_i (HIPRI_MASK),
    .ptr_i        (ptr_q),
    .winner_o     (winner),
    .valid_o      (win_valid)
  );

  // rd and wr together resolves to a read.
  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_wmask = '0;
    sel_rd    = 1'b0;
    sel_idx   = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (winner[p]) begin
        sel_addr  = port_addr_i[p];
        sel_wdata = port_wdata_i[p];
        sel_wmask = port_wmask_i[p];
        sel_rd    = port_rd_i[p];
        sel_idx   = PtrW'(p);
      end
    end
  end

  assign ptr_after  = (sel_idx == PtrW'(NUM_PORTS - 1)) ? '0 : sel_idx + 1'b1;
  // A beat arriving together with the ack is already the first beat.
  assign beats_left = (burst_q ? CntW'(BURST_LEN) : CntW'(1)) - CntW'(sdram_rdy_i);

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= StIdle;
      grant_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
      rd_q    <= 1'b0;
      burst_q <= 1'b0;
      cnt_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      rd_q    <= rd_d;
      burst_q <= burst_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    rd_d    = rd_q;
    burst_d = burst_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      StIdle: begin
        if (win_valid) begin
          state_d = StIssue;
          grant_d = winner;
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
          wmask_d = sel_wmask;
          rd_d    = sel_rd;
          burst_d = sel_rd & (|(winner & BURST_MASK));
          // High-priority grants leave the round-robin pointer alone.
          if (!(|(winner & HIPRI_MASK))) begin
            ptr_d = ptr_after;
          end
        end
      end
      StIssue: begin
        if (sdram_ack_i) begin
          cnt_d = beats_left;
          if (!rd_q || beats_left == '0) begin
            state_d = StIdle;
            grant_d = '0;
          end else begin
            state_d = StData;
          end
        end
      end
      StData: begin
        if (sdram_rdy_i) begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CntW'(1)) begin
            state_d = StIdle;
            grant_d = '0;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    sdram_rd_o = 1'b0;
    sdram_wr_o = 1'b0;
    port_ack_o = '0;
    port_rdy_o = '0;
    unique case (state_q)
      StIssue: begin
        sdram_rd_o = rd_q;
        sdram_wr_o = !rd_q;
        if (sdram_ack_i) begin
          port_ack_o = grant_q;
          if (rd_q && sdram_rdy_i) begin
            port_rdy_o = grant_q;
          end
        end
      end
      StData: begin
        if (sdram_rdy_i) begin
          port_rdy_o = grant_q;
        end
      end
      default: ;
    endcase
  end

  assign sdram_addr_o  = addr_q;
  assign sdram_wdata_o = wdata_q;
  assign sdram_wmask_o = wmask_q;
  assign sdram_burst_o = burst_q;
  assign grant_o       = grant_q;
  assign port_rdata_o  = sdram_rdata_i;

endmodule

// File: tb/tb_sdram_multiport_arbiter.sv
// Randomised bench: transaction-level arbiter/controller model feeds expectation
// queues that a negedge monitor compares against the DUT every cycle.
module tb_sdram_multiport_arbiter;

  localparam int N  = 4;
  localparam int AW = 24;
  localparam int DW = 16;
  localparam int BL = 4;
  localparam logic [N-1:0] BMASK = 4'b0010;
  localparam logic [N-1:0] HMASK = 4'b0010;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [N-1:0]        port_rd, port_wr, port_ack, port_rdy, grant;
  logic [N-1:0][AW-1:0] port_addr;
  logic [N-1:0][DW-1:0] port_wdata;
  logic [N-1:0][1:0]   port_wmask;
  logic [DW-1:0]       port_rdata;
  logic                sdram_rd, sdram_wr, sdram_burst, sdram_ack, sdram_rdy;
  logic [AW-1:0]       sdram_addr;
  logic [DW-1:0]       sdram_wdata, sdram_rdata;
  logic [1:0]          sdram_wmask;

  always #5 clk = ~clk;

  sdram_multiport_arbiter #(
    .NUM_PORTS  (N),
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .BURST_LEN  (BL),
    .BURST_MASK (BMASK),
    .HIPRI_MASK (HMASK)
  ) dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .port_rd_i     (port_rd),
    .port_wr_i     (port_wr),
    .port_addr_i   (port_addr),
    .port_wdata_i  (port_wdata),
    .port_wmask_i  (port_wmask),
    .port_ack_o    (port_ack),
    .port_rdy_o    (port_rdy),
    .port_rdata_o  (port_rdata),
    .sdram_rd_o    (sdram_rd),
    .sdram_wr_o    (sdram_wr),
    .sdram_addr_o  (sdram_addr),
    .sdram_wdata_o (sdram_wdata),
    .sdram_wmask_o (sdram_wmask),
    .sdram_burst_o (sdram_burst),
    .sdram_ack_i   (sdram_ack),
    .sdram_rdy_i   (sdram_rdy),
    .sdram_rdata_i (sdram_rdata),
    .grant_o       (grant)
  );

  typedef struct {
    int            cyc;
    logic [N-1:0]  gnt;
    logic          rd;
    logic          burst;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [1:0]    wmask;
  } cmd_t;

  typedef struct {
    int            cyc;
    logic [N-1:0]  vec;
    logic [DW-1:0] data;
  } evt_t;

  cmd_t cmd_q[$];
  evt_t ack_q[$];
  evt_t beat_q[$];

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int zero_cyc = 1;

  // Master-side model state: requests held until acknowledged.
  logic [N-1:0]         pend, pend_rd, clr;
  logic [AW-1:0]        m_addr [N];
  logic [DW-1:0]        m_wdata[N];
  logic [1:0]           m_wmask[N];

  // Transaction-level view of the arbiter and controller.
  int ptr = 0;
  bit in_cmd = 0, in_data = 0, grant_next = 0, rst_done = 0, post_rst = 0, idle;
  int cur = 0, gport = 0, age = 0, ack_dly = 0, beats_left = 0, beat_idx = 0;
  bit random_data = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
  endtask

  task automatic add_req(int p, logic rd, logic [AW-1:0] a, logic [DW-1:0] d, logic [1:0] m);
    if (!pend[p]) begin
      pend[p]    = 1'b1;
      pend_rd[p] = rd;
      m_addr[p]  = a;
      m_wdata[p] = d;
      m_wmask[p] = m;
    end
  endtask

  function automatic int pick(logic [N-1:0] req, int p0);
    logic [N-1:0] h;
    h = HMASK;
    for (int i = 0; i < N; i++) if (req[i] && h[i]) return i;
    for (int k = 0; k < N; k++) if (req[(p0 + k) % N] && !h[(p0 + k) % N]) return (p0 + k) % N;
    return 0;
  endfunction

  task automatic give_beat();
    evt_t e;
    sdram_rdy   = 1'b1;
    sdram_rdata = random_data ? DW'($urandom) : DW'(16'h1111 * (beat_idx + 1));
    e.cyc  = cyc;
    e.vec  = N'(1) << cur;
    e.data = sdram_rdata;
    beat_q.push_back(e);
    beat_idx++;
    beats_left--;
    if (beats_left == 0) in_data = 0;
  endtask

  initial begin : driver
    logic do_rst;
    logic [N-1:0] h;
    cmd_t c;
    evt_t e;
    h = HMASK;
    rst_n = 1'b0;
    port_rd = '0; port_wr = '0; port_addr = '0; port_wdata = '0; port_wmask = '0;
    sdram_ack = 1'b0; sdram_rdy = 1'b0; sdram_rdata = '0;
    pend = '0; pend_rd = '0; clr = '0;
    for (int p = 0; p < N; p++) begin
      m_addr[p] = '0; m_wdata[p] = '0; m_wmask[p] = '0;
    end
    repeat (3) @(posedge clk);
    for (int t = 0; t < 3000; t++) begin
      @(posedge clk);
      #1;
      cyc++;
      rst_n = 1'b1;
      random_data = (t >= 100);
      pend = pend & ~clr;
      clr  = '0;
      if (grant_next) begin
        grant_next = 0;
        in_cmd  = 1;
        cur     = gport;
        age     = 0;
        ack_dly = $urandom_range(0, 2);
        c.cyc   = cyc;
        c.gnt   = N'(1) << cur;
        c.rd    = pend_rd[cur];
        c.burst = pend_rd[cur] & BMASK[cur];
        c.addr  = m_addr[cur];
        c.wdata = m_wdata[cur];
        c.wmask = m_wmask[cur];
        cmd_q.push_back(c);
      end
      idle = !in_cmd && !in_data;

      if (t == 2) add_req(0, 1'b0, 24'h000123, 16'hBEEF, 2'b01);
      if (t == 15) add_req(1, 1'b1, 24'h000456, 16'h0000, 2'b11);
      if (t >= 40 && t < 80) begin
        add_req(0, 1'b1, AW'($urandom), DW'($urandom), 2'b11);
        add_req(2, 1'b1, AW'($urandom), DW'($urandom), 2'b11);
        add_req(3, 1'b1, AW'($urandom), DW'($urandom), 2'b11);
      end
      if (post_rst) begin
        add_req(3, 1'b0, AW'($urandom), DW'($urandom), 2'b10);
        add_req(0, 1'b0, AW'($urandom), DW'($urandom), 2'b01);
        post_rst = 0;
      end
      if (t >= 100 && t < 2800) begin
        for (int p = 0; p < N; p++)
          if ($urandom_range(0, 99) < 25)
            add_req(p, 1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom), 2'($urandom));
      end

      do_rst = !rst_done && t >= 200 && in_cmd && (cur == 3 || t >= 1500);
      if (do_rst) begin
        rst_n    = 1'b0;
        rst_done = 1;
        zero_cyc = cyc + 1;
      end

      sdram_ack   = 1'b0;
      sdram_rdy   = 1'b0;
      sdram_rdata = DW'($urandom);
      if (in_cmd && !do_rst) begin
        if (age == ack_dly) begin
          sdram_ack = 1'b1;
          e.cyc  = cyc;
          e.vec  = N'(1) << cur;
          e.data = '0;
          ack_q.push_back(e);
          clr[cur] = 1'b1;
          in_cmd   = 0;
          if (pend_rd[cur]) begin
            beats_left = BMASK[cur] ? BL : 1;
            beat_idx   = 0;
            in_data    = 1;
            if ($urandom_range(0, 1) == 1) give_beat();
          end
        end else begin
          age++;
        end
      end else if (in_data) begin
        if ($urandom_range(0, 2) != 0) give_beat();
      end

      for (int p = 0; p < N; p++) begin
        port_rd[p]    = pend[p] & pend_rd[p];
        port_wr[p]    = pend[p] & !pend_rd[p];
        port_addr[p]  = m_addr[p];
        port_wdata[p] = m_wdata[p];
        port_wmask[p] = m_wmask[p];
      end

      if (idle && |pend) begin
        gport      = pick(pend, ptr);
        grant_next = 1;
        if (!h[gport]) ptr = (gport + 1) % N;
      end

      if (do_rst) begin
        in_cmd = 0; in_data = 0; grant_next = 0; ptr = 0;
        pend = '0; clr = '0; post_rst = 1;
      end
    end
    if (!rst_done) check("reset_scenario_reached", 64'(rst_done), 64'(1));
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin : monitor
    cmd_t c;
    evt_t e;
    logic cmd_now, prev_cmd, prev_rst_n;
    logic [N-1:0] exp_vec, prev_req, prev_ack;
    prev_cmd = 1'b0; prev_rst_n = 1'b0; prev_req = '0; prev_ack = '0;
    forever begin
      @(negedge clk);
      if (cyc == 0) continue;

      for (int p = 0; p < N; p++) begin
        assert (!(port_rd[p] && port_wr[p]))
          else $error("FAIL illegal rd and wr together on port %0d", p);
        assert (!(rst_n && prev_rst_n && prev_req[p] && !prev_ack[p] && !(port_rd[p] || port_wr[p])))
          else $error("FAIL request dropped before ack on port %0d", p);
      end

      if (cyc == zero_cyc) begin
        check("reset_ctrl_zero",
              64'({sdram_rd, sdram_wr, sdram_burst, sdram_wmask, port_ack, port_rdy, grant}), 64'(0));
        check("reset_addr_zero", 64'(sdram_addr), 64'(0));
        check("reset_wdata_zero", 64'(sdram_wdata), 64'(0));
      end

      cmd_now = sdram_rd | sdram_wr;
      if (cmd_q.size() > 0 && cmd_q[0].cyc == cyc) begin
        c = cmd_q.pop_front();
        check("cmd_start", 64'(cmd_now && !prev_cmd), 64'(1));
        check("cmd_grant", 64'(grant), 64'(c.gnt));
        check("cmd_dir", 64'({sdram_rd, sdram_wr}), 64'(c.rd ? 2'b10 : 2'b01));
        check("cmd_addr", 64'(sdram_addr), 64'(c.addr));
        check("cmd_burst", 64'(sdram_burst), 64'(c.burst));
        if (!c.rd) begin
          check("cmd_wdata", 64'(sdram_wdata), 64'(c.wdata));
          check("cmd_wmask", 64'(sdram_wmask), 64'(c.wmask));
        end
      end else begin
        check("no_spurious_cmd", 64'(cmd_now && !prev_cmd), 64'(0));
      end
      prev_cmd = cmd_now;

      exp_vec = '0;
      if (ack_q.size() > 0 && ack_q[0].cyc == cyc) begin
        e = ack_q.pop_front();
        exp_vec = e.vec;
      end
      check("port_ack", 64'(port_ack), 64'(exp_vec));

      exp_vec = '0;
      if (beat_q.size() > 0 && beat_q[0].cyc == cyc) begin
        e = beat_q.pop_front();
        exp_vec = e.vec;
        check("port_rdata", 64'(port_rdata), 64'(e.data));
      end
      check("port_rdy", 64'(port_rdy), 64'(exp_vec));

      prev_req   = port_rd | port_wr;
      prev_ack   = port_ack;
      prev_rst_n = rst_n;
    end
  end

endmodule
